// File: rtl/bnn_weight_sequencer.sv
// Weight-load sequencer for the BNN core: takes a handshaked byte stream, replays each
// byte as two nibble load beats (low first), then checks a trailing XOR checksum byte.
module bnn_weight_sequencer #(
  parameter int unsigned NUM_NEURONS = 12,
  parameter int unsigned IDX_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             load_en,
  output logic [3:0]       load_nibble,
  output logic [IDX_W-1:0] neuron_idx,
  output logic             busy,
  output logic             done,
  output logic             chk_err
);

  typedef enum logic [2:0] {StIdle, StWait, StLo, StHi, StChk, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       xor_q, xor_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             last_byte;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      byte_q  <= 8'h00;
      xor_q   <= 8'h00;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      xor_q   <= xor_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign last_byte = (idx_q == LastIdx);

  // Moore outputs, all decoded from registered state
  always_comb begin
    in_ready    = 1'b0;
    load_en     = 1'b0;
    load_nibble = 4'h0;
    unique case (state_q)
      StWait: in_ready = 1'b1;
      StLo: begin
        load_en     = 1'b1;
        load_nibble = byte_q[3:0];
      end
      StHi: begin
        load_en     = 1'b1;
        load_nibble = byte_q[7:4];
        in_ready    = ~last_byte;
      end
      StChk:   in_ready = 1'b1;
      default: ;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign neuron_idx = idx_q;
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);
  assign chk_err    = err_q;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    xor_d   = xor_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWait;
          idx_d   = '0;
          xor_d   = 8'h00;
          err_d   = 1'b0;
        end
      end
      StWait: begin
        if (accept) begin
          byte_d  = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = StLo;
        end
      end
      StLo: state_d = StHi;
      StHi: begin
        idx_d = idx_q + IDX_W'(1);
        if (last_byte) begin
          state_d = StChk;
        end else if (accept) begin
          // Back-to-back: next byte's low nibble follows immediately
          byte_d  = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = StLo;
        end else begin
          state_d = StWait;
        end
      end
      StChk: begin
        if (accept) begin
          err_d   = (in_data != xor_q);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_bnn_weight_sequencer.sv
// Directed bench for bnn_weight_sequencer: a transaction-level model of the expected nibble
// stream and neuron count is checked every cycle, plus literal end-of-session expectations.
module tb_bnn_weight_sequencer;

  localparam int NumNeurons = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, load_en, busy, done, chk_err;
  logic [3:0] load_nibble;
  logic [4:0] neuron_idx;

  bnn_weight_sequencer #(
    .NUM_NEURONS(NumNeurons),
    .IDX_W      (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_en    (load_en),
    .load_nibble(load_nibble),
    .neuron_idx (neuron_idx),
    .busy       (busy),
    .done       (done),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  int         npass = 0;
  int         ntotal = 0;
  logic [7:0] wbytes[NumNeurons];
  int         n_sent, nib_cnt, run, max_run;
  bit         last_acc;
  logic [7:0] bb[NumNeurons];
  logic [7:0] sb[NumNeurons];
  logic [7:0] sx;

  task automatic chk(input string nm, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  nm, act, act, exp, exp, $time);
  endtask

  task automatic clear_model();
    n_sent  = 0;
    nib_cnt = 0;
    run     = 0;
    max_run = 0;
  endtask

  // Expected: bytes accepted so far, emitted in order as lo,hi nibble pairs
  task automatic model_check();
    logic [7:0] b;
    if (reset) begin
      clear_model();
      return;
    end
    chk("neuron_idx", int'(neuron_idx), nib_cnt / 2);
    if (load_en) begin
      if (nib_cnt >= 2 * n_sent) begin
        chk("nibble_without_byte", 0, 1);
      end else begin
        b = wbytes[nib_cnt / 2];
        chk("load_nibble", int'(load_nibble), (nib_cnt % 2 == 0) ? int'(b[3:0]) : int'(b[7:4]));
      end
      if (nib_cnt % 2 == 0) chk("in_ready_in_lo", int'(in_ready), 0);
      nib_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      chk("nibble_zero_when_idle", int'(load_nibble), 0);
      chk("pair_intact", nib_cnt % 2, 0);
      run = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    last_acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit weight, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 64; t++) begin
      tick();
      if (last_acc) begin
        if (weight && n_sent < NumNeurons) begin
          wbytes[n_sent] = b;
          n_sent++;
        end
        return;
      end
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic start_session();
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    clear_model();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_in_ready"}, int'(in_ready), 0);
    chk({nm, "_load_en"}, int'(load_en), 0);
    chk({nm, "_load_nibble"}, int'(load_nibble), 0);
    chk({nm, "_neuron_idx"}, int'(neuron_idx), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_chk_err"}, int'(chk_err), 0);
  endtask

  initial begin
    clear_model();
    bb = '{8'hE0, 8'h70, 8'hB0, 8'hD0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'hF0, 8'h80};

    // Reset values, then IDLE ignores a valid source
    repeat (2) tick();
    check_all_zero("reset");
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_busy", int'(busy), 0);
    in_valid = 1'b0;

    // Reset asserted during HI clears outputs in the same cycle
    start_session();
    chk("wait_in_ready", int'(in_ready), 1);
    chk("wait_busy", int'(busy), 1);
    send_byte(8'h3C, 1'b1, 0);
    in_valid = 1'b0;
    tick();
    chk("hi_load_en", int'(load_en), 1);
    chk("hi_nibble", int'(load_nibble), 3);
    reset = 1'b1;
    #1;
    check_all_zero("mid_hi_reset");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", int'(in_ready), 0);
    chk("post_reset_busy", int'(busy), 0);

    // Back-to-back session with good checksum (XOR of bb is 8'hF0)
    start_session();
    for (int i = 0; i < NumNeurons; i++) send_byte(bb[i], 1'b1, 0);
    send_byte(8'hF0, 1'b0, 0);
    chk("b2b_done", int'(done), 1);
    chk("b2b_chk_err", int'(chk_err), 0);
    chk("b2b_neuron_idx", int'(neuron_idx), 12);
    chk("b2b_busy", int'(busy), 0);
    chk("b2b_nibbles", nib_cnt, 24);
    chk("b2b_load_run", max_run, 24);

    // DONE ignores a valid source
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (3) tick();
    chk("done_in_ready", int'(in_ready), 0);
    chk("done_held", int'(done), 1);
    chk("done_chk_err", int'(chk_err), 0);
    in_valid = 1'b0;

    // Bad checksum: 12 x FF gives XOR 00, send 01
    start_session();
    for (int i = 0; i < NumNeurons; i++) send_byte(8'hFF, 1'b1, 0);
    send_byte(8'h01, 1'b0, 0);
    in_valid = 1'b0;
    chk("bad_done", int'(done), 1);
    chk("bad_chk_err", int'(chk_err), 1);
    chk("bad_neuron_idx", int'(neuron_idx), 12);

    // A new start clears done and chk_err; stalled source, with a start pulse mid-session
    start_session();
    chk("restart_done", int'(done), 0);
    chk("restart_chk_err", int'(chk_err), 0);
    chk("restart_neuron_idx", int'(neuron_idx), 0);
    sx = 8'h00;
    for (int i = 0; i < NumNeurons; i++) begin
      sb[i] = 8'(i * 29 + 7);
      sx    = sx ^ sb[i];
    end
    for (int i = 0; i < NumNeurons; i++) begin
      send_byte(sb[i], 1'b1, int'($urandom_range(0, 3)));
      if (i == 4) begin
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("start_ignored_busy", int'(busy), 1);
      end
    end
    send_byte(sx, 1'b0, int'($urandom_range(0, 3)));
    in_valid = 1'b0;
    chk("stall_done", int'(done), 1);
    chk("stall_chk_err", int'(chk_err), 0);
    chk("stall_neuron_idx", int'(neuron_idx), 12);
    chk("stall_nibbles", nib_cnt, 24);
    repeat (2) tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/bnn_weight_sequencer.md
# bnn_weight_sequencer

Upstream weight-load sequencer for the 8-8-4 BNN core. Accepts a byte stream of neuron weights over a valid/ready handshake and replays each byte as two nibble beats with a load strobe, low nibble first, matching the core's two-cycle-per-neuron load protocol. Exactly NUM_NEURONS bytes are emitted per session, keeping the core's internal neuron pointer aligned. A trailing XOR checksum byte is verified, and the result is reported as a sticky error flag.

## Interface
- NUM_NEURONS, 12: weight bytes per load session; neuron indices 0..NUM_NEURONS-1.
- IDX_W, 5: width of neuron_idx; must hold NUM_NEURONS.
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  begin a session; sampled only in IDLE or DONE.
- in_valid  input  1  source has a byte; source holds in_data stable until accepted.
- in_data  input  8  weight byte (bit 7 = weight bit 7) or checksum byte.
- in_ready  output  1  sequencer accepts in_data this cycle.
- load_en  output  1  load strobe to core (drives uio[3]).
- load_nibble  output  4  nibble to core (drives uio[7:4]).
- neuron_idx  output  IDX_W  count of weight bytes fully emitted in this session.
- busy  output  1  session in progress (any state except IDLE and DONE).
- done  output  1  session complete; held until the next start.
- chk_err  output  1  checksum mismatch; sticky until the next start.

## Operation
- States: IDLE, WAIT, LO, HI, CHK, DONE. The byte register, byte counter, and running XOR are internal.
- All outputs are Moore, derived from registered state.
- IDLE: in_ready=0, load_en=0. start=1 -> WAIT. Entering WAIT from a start clears neuron_idx, the XOR, done, and chk_err.
- WAIT: in_ready=1. in_valid=1 -> latch byte, XOR ^= byte, go to LO. Otherwise stay.
- LO: load_en=1, load_nibble=byte[3:0], in_ready=0 -> HI.
- HI: load_en=1, load_nibble=byte[7:4]. neuron_idx increments on exit.
  - If this is the last byte (neuron_idx==NUM_NEURONS-1 on entry): in_ready=0 -> CHK.
  - Otherwise in_ready=1. A byte accepted in the same cycle is latched and XORed, and the next state is LO (back-to-back). With no byte -> WAIT.
- CHK: in_ready=1, load_en=0. A byte accepted -> set chk_err if byte != XOR, then go to DONE.
- DONE: done=1, in_ready=0, load_en=0. start=1 -> WAIT with clears as above. Otherwise hold.
- load_nibble=0 whenever load_en=0.
- start is ignored in WAIT/LO/HI/CHK; the session continues.
- in_valid is ignored when in_ready=0; no byte is lost or duplicated.
- A session always emits exactly NUM_NEURONS byte pairs. There is no abort except reset.
- The weight-stream handshake occurs only when in_valid and in_ready are both 1 at a rising edge.
- In checksum arithmetic, the XOR is 8-bit and initialised to 8'h00.
- neuron_idx saturates at NUM_NEURONS in CHK/DONE; it never wraps within a session.

## Timing
- Reset (async assert, sync deassert assumed) -> state IDLE. in_ready=0, load_en=0, load_nibble=0, neuron_idx=0, busy=0, done=0, chk_err=0.
- start sampled at edge T -> WAIT visible in cycle T+1 with in_ready=1.
- Byte accepted at edge A: LO in cycle A+1 (core samples the low nibble at edge A+2), HI in cycle A+2 (core samples the high nibble at edge A+3).
- Throughput is 2 cycles/byte with a continuous source. Minimum session length is start + 1 + 2*NUM_NEURONS + 1 (checksum) cycles to DONE.
- The checksum accepted at edge C gives done=1 and valid chk_err from cycle C+1.
- Reset mid-session returns to IDLE immediately. The core shares reset, so its neuron pointer is also cleared.
- The core's ena must be high during LO/HI. This is the system integrator's responsibility; the sequencer does not observe ena.

## Test plan
- Reset values: assert reset mid-HI -> all outputs 0 in the same cycle. After release, state is IDLE with in_ready=0.
- Back-to-back load: start, then 12 continuous bytes 8'hE0, 8'h70, ..., 8'h80, then checksum = their XOR.
  - load_en high for 24 consecutive cycles; nibble sequence 0,E,0,7,...
  - neuron_idx reaches 12, done=1, chk_err=0.
  - The core's weights match the bytes and its output equals the model for ui_in=8'hA5.
- Stalled source: in_valid toggled pseudo-randomly -> load_en pairs are never split; no duplicated or dropped bytes; nibble order is preserved.
- Bad checksum: 12 bytes of 8'hFF followed by checksum 8'h01 (expected 8'h00) -> done=1, chk_err=1. A following start clears both.
- start while busy: pulse start during byte 5 -> no effect. neuron_idx keeps counting to 12.
- Ready gating: in_valid held high while in LO, CHK→DONE, and IDLE -> no acceptance, and in_ready=0 in those cycles.
